fetch_pc_unit: RTL and testbench

- Program-counter and instruction-fetch stage that sits directly around the 32-bit 4-input next-PC mux.
- Drives the mux select and the PC+4 operand (mux input A), and consumes the mux output as the next PC.
- Issues one-outstanding instruction-memory requests and buffers returned instructions in a 2-entry FIFO toward decode.
- Mux input mapping: sel 0 = A = PC+4, 1 = B = branch target, 2 = C = register jump, 3 = D = jump target (shifted externally).

---
 rtl/fetch_pc_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage around an external 4-input next-PC mux.
// Keeps one memory request in flight and buffers returned instructions in a 2-entry FIFO.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic        jump_reg,
    input  logic        jump,
    input  logic        stall,
    input  logic [31:0] next_pc,
    output logic [1:0]  mux_sel,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic        discard_r;
    logic        discard_s;

    logic [31:0] fifo_pc_r    [2];
    logic [31:0] fifo_instr_r [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;

    logic        redirect_s;
    logic        outstanding_s;
    logic [1:0]  occupancy_s;
    logic        space_s;
    logic        req_s;
    logic        accept_s;
    logic        resp_s;
    logic        push_s;
    logic        pop_s;
    logic        pc_load_s;

    assign redirect_s    = branch_taken | jump_reg | jump;
    assign outstanding_s = (state_r == ST_WAIT);
    // Buffered entries plus the in-flight fetch must leave room for its response.
    assign occupancy_s   = count_r + {1'b0, outstanding_s};
    assign space_s       = (occupancy_s < 2'd2);
    assign req_s         = (state_r == ST_REQ) && !stall && space_s;
    assign accept_s      = req_s && imem_gnt;
    assign resp_s        = (state_r == ST_WAIT) && imem_rvalid;
    assign push_s        = resp_s && !discard_r && !redirect_s;
    assign pop_s         = (count_r != 2'd0) && if_ready && !redirect_s;
    assign pc_load_s     = redirect_s | accept_s;

    assign pc_plus4  = pc_r + 32'd4;
    assign imem_addr = pc_r;
    assign imem_req  = req_s;
    assign if_valid  = (count_r != 2'd0);
    assign if_instr  = fifo_instr_r[rd_ptr_r];
    assign if_pc     = fifo_pc_r[rd_ptr_r];

    // Next-PC mux select, highest-priority redirect wins.
    always_comb begin
        mux_sel = 2'd0;
        if (jump) begin
            mux_sel = 2'd3;
        end else if (jump_reg) begin
            mux_sel = 2'd2;
        end else if (branch_taken) begin
            mux_sel = 2'd1;
        end else begin
            mux_sel = 2'd0;
        end
    end

    // Fetch FSM next state and discard flag for the in-flight response.
    always_comb begin
        state_s   = state_r;
        discard_s = discard_r;
        case (state_r)
            ST_IDLE: begin
                state_s   = ST_REQ;
                discard_s = 1'b0;
            end
            ST_REQ: begin
                if (accept_s) begin
                    state_s   = ST_WAIT;
                    discard_s = redirect_s;
                end else begin
                    state_s   = ST_REQ;
                    discard_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (resp_s) begin
                    state_s   = ST_REQ;
                    discard_s = 1'b0;
                end else if (redirect_s) begin
                    state_s   = ST_WAIT;
                    discard_s = 1'b1;
                end else begin
                    state_s   = ST_WAIT;
                    discard_s = discard_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                discard_s = 1'b0;
            end
        endcase
    end

    // State, PC and captured request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            discard_r <= 1'b0;
            pc_r      <= RESET_PC;
            req_pc_r  <= 32'd0;
        end else begin
            state_r   <= state_s;
            discard_r <= discard_s;
            if (pc_load_s) begin
                pc_r <= next_pc;
            end
            if (accept_s) begin
                req_pc_r <= pc_r;
            end
        end
    end

    // Two-entry output FIFO; a redirect empties it and drops any same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_r[i]    <= 32'd0;
                fifo_instr_r[i] <= 32'd0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (redirect_s) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= req_pc_r;
                fifo_instr_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r               <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: select table, directed corner sequences, and a randomized run
// scored against a program-order model of the delivered instruction stream.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        branch_taken, jump_reg, jump, stall;
    logic [31:0] next_pc;
    logic [1:0]  mux_sel;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [31:0] bt, rt, jt;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .jump_reg(jump_reg),
        .jump(jump), .stall(stall), .next_pc(next_pc), .mux_sel(mux_sel),
        .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    // External next-PC mux
    assign next_pc = (mux_sel == 2'd3) ? jt : (mux_sel == 2'd2) ? rt :
                     (mux_sel == 2'd1) ? bt : pc_plus4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pend_cnt = 0;
    logic [31:0] pend_addr;
    int lat = 1;
    bit rand_lat = 0;
    bit auto_gnt = 0;
    int gnt_pct = 100;
    logic [31:0] exp_next;
    logic [31:0] obs[$];
    int first_gnt, first_vld, deliveries;
    logic [31:0] first_gnt_addr, last_gnt_addr;
    bit gnt_seen;

    typedef struct {
        logic br; logic jr; logic j;
        logic [1:0] sel; logic [31:0] addr;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check the current cycle, then act as memory for the next one.
    task automatic step();
        logic grant_now;
        logic redir;
        logic [1:0] exp_sel;
        logic [31:0] addr_now;
        #1;
        redir   = branch_taken | jump_reg | jump;
        exp_sel = jump ? 2'd3 : (jump_reg ? 2'd2 : (branch_taken ? 2'd1 : 2'd0));
        chk("mux_sel", 32'(mux_sel), 32'(exp_sel));
        chk("pc_plus4", pc_plus4, imem_addr + 32'd4);
        if (imem_req) chk("req_while_outstanding", 32'(pend_cnt != 0), 32'd0);
        if (rst_n && redir) begin
            exp_next = jump ? jt : (jump_reg ? rt : bt);
        end else if (rst_n && if_valid && if_ready) begin
            chk("deliver_pc", if_pc, exp_next);
            chk("deliver_instr", if_instr, mem_word(exp_next));
            obs.push_back(if_pc);
            exp_next = exp_next + 32'd4;
            deliveries++;
        end
        grant_now = imem_req & imem_gnt;
        addr_now  = imem_addr;
        if (if_valid && first_vld < 0) first_vld = cyc;
        if (grant_now && first_gnt < 0) begin
            first_gnt      = cyc;
            first_gnt_addr = addr_now;
        end
        gnt_seen = grant_now;
        if (grant_now) last_gnt_addr = addr_now;
        @(posedge clk);
        #2;
        cyc++;
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        jump_reg     = 1'b0;
        jump         = 1'b0;
        if (grant_now) begin
            pend_addr = addr_now;
            pend_cnt  = rand_lat ? int'($urandom_range(1, 3)) : lat;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
        if (auto_gnt) imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    endtask

    task automatic clear_model();
        pend_cnt  = 0;
        exp_next  = RESET_PC;
        obs.delete();
        first_gnt = -1;
        first_vld = -1;
        first_gnt_addr = 32'hFFFF_FFFF;
        gnt_seen  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        branch_taken = 1'b0; jump_reg = 1'b0; jump = 1'b0; stall = 1'b0;
        imem_rvalid = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0;
        clear_model();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n0, n1;
        logic [31:0] a0;
        int r;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h200};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h200};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h300};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h400};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'h400};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h400};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h300};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h400};
        bt = 32'h200; rt = 32'h300; jt = 32'h400;
        imem_rdata = 32'd0;
        deliveries = 0;

        // Reset values while rst_n is low
        rst_n = 1'b0;
        branch_taken = 1'b0; jump_reg = 1'b0; jump = 1'b0; stall = 1'b0;
        imem_rvalid = 1'b0; imem_gnt = 1'b0; if_ready = 1'b0;
        #2;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);

        // Select/redirect table under stall: pc only moves on a redirect
        auto_gnt = 1'b0;
        do_reset();
        stall = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            bt = 32'h200; rt = 32'h300; jt = 32'h400;
            branch_taken = vecs[i].br; jump_reg = vecs[i].jr; jump = vecs[i].j;
            #1;
            chk("tbl_mux_sel", 32'(mux_sel), 32'(vecs[i].sel));
            chk("tbl_no_req", 32'(imem_req), 32'd0);
            step();
            #1;
            chk("tbl_addr", imem_addr, vecs[i].addr);
            chk("tbl_plus4", pc_plus4, vecs[i].addr + 32'd4);
        end
        stall = 1'b0;

        // Sequential fetch and gnt-to-if_valid latency
        auto_gnt = 1'b1; gnt_pct = 100; lat = 1; rand_lat = 0;
        do_reset();
        if_ready = 1'b1;
        repeat (16) step();
        chk("t1_count", 32'(obs.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) chk("t1_if_pc", (obs.size() > i) ? obs[i] : 32'hFFFF_FFFF, 32'(4 * i));
        chk("t1_latency", 32'(first_vld - first_gnt), 32'd2);
        chk("t1_first_addr", first_gnt_addr, RESET_PC);

        // Jump while waiting on the fetch of 0x8
        lat = 2;
        do_reset();
        if_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (gnt_seen && last_gnt_addr == 32'h8) found = 1'b1;
        end
        chk("t2_reach_0x8", 32'(found), 32'd1);
        n0 = obs.size();
        jt = 32'h100; jump = 1'b1;
        #1;
        chk("t2_mux_sel", 32'(mux_sel), 32'd3);
        step();
        repeat (12) step();
        chk("t2_prev_4", (n0 >= 2) ? obs[n0 - 1] : 32'hFFFF_FFFF, 32'h4);
        chk("t2_after_jump", (obs.size() > n0) ? obs[n0] : 32'hFFFF_FFFF, 32'h100);

        // jump_reg + branch together with a grant and a non-empty FIFO
        lat = 1;
        do_reset();
        if_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            #1;
            if (if_valid && imem_req && imem_gnt) found = 1'b1;
            else step();
        end
        chk("t3_setup", 32'(found), 32'd1);
        bt = 32'h200; rt = 32'h300;
        branch_taken = 1'b1; jump_reg = 1'b1;
        #1;
        chk("t3_mux_sel", 32'(mux_sel), 32'd2);
        step();
        #1;
        chk("t3_flushed", 32'(if_valid), 32'd0);
        chk("t3_pc", imem_addr, 32'h300);
        if_ready = 1'b1;
        repeat (10) step();
        chk("t3_first", (obs.size() > 0) ? obs[0] : 32'hFFFF_FFFF, 32'h300);

        // Backpressure: FIFO fills, requests stop, then drain in order
        do_reset();
        if_ready = 1'b0;
        repeat (8) step();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t4_req_blocked", 32'(imem_req), 32'd0);
            chk("t4_valid_held", 32'(if_valid), 32'd1);
            step();
        end
        if_ready = 1'b1;
        repeat (12) step();
        chk("t4_count", 32'(obs.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) chk("t4_order", (obs.size() > i) ? obs[i] : 32'hFFFF_FFFF, 32'(4 * i));

        // Wrap at the top of the address space, then stall with a branch inside it
        do_reset();
        if_ready = 1'b1;
        step();
        step();
        n0 = obs.size();
        jt = 32'hFFFF_FFFC; jump = 1'b1;
        step();
        #1;
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("t5_plus4_wrap", pc_plus4, 32'h0);
        repeat (8) step();
        chk("t5_top", (obs.size() > n0) ? obs[n0] : 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        chk("t5_wrap", (obs.size() > n0 + 1) ? obs[n0 + 1] : 32'hFFFF_FFFF, 32'h0);
        stall = 1'b1;
        #1;
        a0 = imem_addr;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("t5_stall_req", 32'(imem_req), 32'd0);
            chk("t5_stall_pc", imem_addr, a0);
        end
        n1 = obs.size();
        bt = 32'h500; branch_taken = 1'b1;
        step();
        #1;
        chk("t5_stall_branch", imem_addr, 32'h500);
        chk("t5_stall_branch_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        repeat (8) step();
        chk("t5_after_branch", (obs.size() > n1) ? obs[n1] : 32'hFFFF_FFFF, 32'h500);

        // Asynchronous reset in the middle of a wait, with a stale response afterwards
        lat = 3;
        do_reset();
        if_ready = 1'b1;
        step();
        step();
        chk("t6_in_wait", 32'(pend_cnt > 0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(if_valid), 32'd0);
        chk("t6_if_pc", if_pc, 32'd0);
        chk("t6_if_instr", if_instr, 32'd0);
        chk("t6_addr", imem_addr, RESET_PC);
        clear_model();
        step();
        step();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        repeat (12) step();
        chk("t6_first_req", first_gnt_addr, RESET_PC);
        chk("t6_first_pc", (obs.size() > 0) ? obs[0] : 32'hFFFF_FFFF, RESET_PC);

        // Randomized run scored against the program-order model
        auto_gnt = 1'b1; gnt_pct = 60; rand_lat = 1;
        do_reset();
        deliveries = 0;
        for (int k = 0; k < 3000; k++) begin
            stall    = ($urandom_range(0, 99) < 15);
            if_ready = ($urandom_range(0, 99) < 70);
            r = int'($urandom_range(0, 99));
            bt = $urandom() & 32'hFFFF_FFFC;
            rt = $urandom() & 32'hFFFF_FFFC;
            jt = $urandom() & 32'hFFFF_FFFC;
            branch_taken = (r < 3) || (r == 9);
            jump_reg     = (r >= 3 && r < 6) || (r == 9);
            jump         = (r >= 6 && r < 9) || (r == 9);
            step();
        end
        stall = 1'b0;
        if_ready = 1'b1;
        repeat (20) step();
        chk("rand_progress", 32'(deliveries >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
